// File: rtl/apb_reg_pkg.sv
// apb_reg_pkg: register offsets, wait-state FSM encoding and byte-lane merge helper
package apb_reg_pkg;
  localparam int OFS_ID       = 'h00;
  localparam int OFS_CTRL     = 'h04;
  localparam int OFS_STATUS   = 'h08;
  localparam int OFS_INT_STAT = 'h0C;
  localparam int OFS_INT_EN   = 'h10;
  localparam int OFS_SCRATCH  = 'h14;
  typedef enum logic {IDLE, COUNT} state_t;
  function automatic logic [31:0] byte_merge(input logic [31:0] old, input logic [31:0] wdata, input logic [3:0] strb);
    byte_merge = old;
    for (int i = 0; i < 4; i++)
      if (strb[i]) byte_merge[8*i +: 8] = wdata[8*i +: 8];
  endfunction
endpackage

// File: rtl/apb_reg_bank_if.sv
// apb_reg_bank_if: decoded local bus between the APB slave stage (master) and the register bank (slave)
// signals: addr, rd, wr, b_strobe, wdata toward the bank; rdata, pready_r, pslverr_r back
interface apb_reg_bank_if #(parameter int ADDR_WIDTH = 12) ();
  logic [ADDR_WIDTH-1:0] addr;
  logic rd;
  logic wr;
  logic [3:0] b_strobe;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic pready_r;
  logic pslverr_r;
  modport master(output addr, rd, wr, b_strobe, wdata, input rdata, pready_r, pslverr_r);
  modport slave(input addr, rd, wr, b_strobe, wdata, output rdata, pready_r, pslverr_r);
endinterface

// File: rtl/apb_wait_gen.sv
// apb_wait_gen: inserts WAIT_CYCLES wait states per access, raising pready_r for one cycle
// ports: pclk/prst clock and sync reset; rd/wr access phase in; pready_r completion, commit = completing write
module apb_wait_gen
  import apb_reg_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic pclk,
  input  logic prst,
  input  logic rd,
  input  logic wr,
  output logic pready_r,
  output logic commit
);
  state_t st;
  logic [3:0] cnt;
  logic act;
  always_comb begin
    act = rd | wr;
    pready_r = (WAIT_CYCLES == 0) ? act && st == IDLE : act && st == COUNT && cnt == 4'(WAIT_CYCLES - 1);
    commit = pready_r & wr;
  end
  // leaving COUNT on a dropped rd|wr is the abort path; no commit can occur since pready_r needs act
  always_ff @(posedge pclk)
    if (prst) begin
      st <= IDLE;
      cnt <= '0;
    end else if (st == IDLE) begin
      if (act && WAIT_CYCLES > 0) begin
        st <= COUNT;
        cnt <= '0;
      end
    end else begin
      if (!act || pready_r) st <= IDLE;
      cnt <= cnt + 4'd1;
    end
endmodule

// File: rtl/apb_reg_bank.sv
// apb_reg_bank: ID/CTRL/STATUS/INT_STAT/INT_EN/SCRATCH register bank with programmable wait states
// ports: pclk/prst clock and sync reset; bus decoded local bus; ecorevnum ID[3:0]; status_in live status;
//        ctrl_out CTRL contents; irq registered level interrupt
module apb_reg_bank
  import apb_reg_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int WAIT_CYCLES = 1,
  parameter logic [27:0] ID_CODE = 28'h000A5B0
) (
  input  logic pclk,
  input  logic prst,
  apb_reg_bank_if.slave bus,
  input  logic [3:0] ecorevnum,
  input  logic [DATA_WIDTH-1:0] status_in,
  output logic [DATA_WIDTH-1:0] ctrl_out,
  output logic irq
);
  logic [DATA_WIDTH-1:0] ctrl, int_stat, int_en, scratch, status_q, clr;
  logic [ADDR_WIDTH-1:0] a;
  logic h_id, h_ctrl, h_st, h_ist, h_en, h_scr, mapped, pready, commit, err, we;
  apb_wait_gen #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
    .pclk(pclk), .prst(prst), .rd(bus.rd), .wr(bus.wr), .pready_r(pready), .commit(commit)
  );
  always_comb begin
    a = {bus.addr[ADDR_WIDTH-1:2], 2'b00};
    h_id = a == ADDR_WIDTH'(OFS_ID);
    h_ctrl = a == ADDR_WIDTH'(OFS_CTRL);
    h_st = a == ADDR_WIDTH'(OFS_STATUS);
    h_ist = a == ADDR_WIDTH'(OFS_INT_STAT);
    h_en = a == ADDR_WIDTH'(OFS_INT_EN);
    h_scr = a == ADDR_WIDTH'(OFS_SCRATCH);
    mapped = h_id | h_ctrl | h_st | h_ist | h_en | h_scr;
    err = pready & (!mapped | (bus.wr & (h_id | h_st)));
    we = commit & !err;
    // W1C mask: only strobed lanes of wdata may clear bits
    clr = (we && h_ist) ? byte_merge('0, bus.wdata, bus.b_strobe) : '0;
    bus.pready_r = pready;
    bus.pslverr_r = err;
    bus.rdata = !bus.rd ? '0 :
                h_id    ? {ID_CODE, ecorevnum} :
                h_ctrl  ? ctrl :
                h_st    ? status_in :
                h_ist   ? int_stat :
                h_en    ? int_en :
                h_scr   ? scratch : '0;
    ctrl_out = ctrl;
  end
  always_ff @(posedge pclk)
    if (prst) begin
      ctrl <= '0;
      int_stat <= '0;
      int_en <= '0;
      scratch <= '0;
      status_q <= '0;
      irq <= 1'b0;
    end else begin
      status_q <= status_in;
      // rising-edge set is OR-ed after the clear so a same-cycle set wins
      int_stat <= (int_stat & ~clr) | (status_in & ~status_q);
      irq <= |(int_stat & int_en);
      if (we && h_ctrl) ctrl <= byte_merge(ctrl, bus.wdata, bus.b_strobe);
      if (we && h_en) int_en <= byte_merge(int_en, bus.wdata, bus.b_strobe);
      if (we && h_scr) scratch <= byte_merge(scratch, bus.wdata, bus.b_strobe);
    end
endmodule
